regn_ld_step: RTL and testbench



---
 rtl/regn_ld_step.sv | 79 +++++++
 tb/tb_regn_ld_step.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/regn_ld_step.sv
// regn_ld_step: WIDTH-bit load/step/shift register with wrap or saturate arithmetic and status flags.
// Optional sticky overflow/underflow flags enabled by defining REGN_LD_STEP_STICKY_EN.
module regn_ld_step #(
  parameter int WIDTH = 8,
  parameter int STEP = 1,
  parameter bit SATURATE = 1'b0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             inc,
  input  logic             dec,
  input  logic             shl,
  input  logic             shr,
  input  logic             sin,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             max,
  output logic             carry,
  output logic             borrow,
  output logic             sout
`ifdef REGN_LD_STEP_STICKY_EN
  ,
  input  logic             clr_flags,
  output logic             ovf_sticky,
  output logic             unf_sticky
`endif
);
  if (WIDTH < 2 || STEP < 1 || (WIDTH < 31 && STEP >= (1 << WIDTH))) begin : g_bad_param
    $error("regn_ld_step: WIDTH must be >= 2 and STEP within 1..2^WIDTH-1");
  end
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  logic [WIDTH:0] sum, diff;
  logic [WIDTH-1:0] nxt;
  logic nxt_carry, nxt_borrow;
  assign sum  = {1'b0, out} + {1'b0, STEP_W};
  assign diff = {1'b0, out} - {1'b0, STEP_W};
  // Overflow/underflow only count when the step actually executes (not ld, not cancelled inc+dec).
  always_comb begin
    nxt_carry  = !ld && inc && !dec && sum[WIDTH];
    nxt_borrow = !ld && dec && !inc && diff[WIDTH];
    nxt = ld          ? in :
          (inc & dec) ? out :
          inc         ? ((SATURATE && sum[WIDTH]) ? '1 : sum[WIDTH-1:0]) :
          dec         ? ((SATURATE && diff[WIDTH]) ? '0 : diff[WIDTH-1:0]) :
          (shl & shr) ? out :
          shl         ? {out[WIDTH-2:0], sin} :
          shr         ? {sin, out[WIDTH-1:1]} :
                        out;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out    <= RST_VAL;
      carry  <= 1'b0;
      borrow <= 1'b0;
    end else begin
      out    <= nxt;
      carry  <= nxt_carry;
      borrow <= nxt_borrow;
    end
  end
  assign zero = (out == '0);
  assign max  = (out == '1);
  assign sout = shl ? out[WIDTH-1] : out[0];
`ifdef REGN_LD_STEP_STICKY_EN
  // A set event on the same edge as clr_flags wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
      unf_sticky <= 1'b0;
    end else begin
      ovf_sticky <= nxt_carry | (ovf_sticky & ~clr_flags);
      unf_sticky <= nxt_borrow | (unf_sticky & ~clr_flags);
    end
  end
`endif
endmodule

// File: tb/tb_regn_ld_step.sv
// tb_regn_ld_step: randomized scoreboard bench for two regn_ld_step configurations (wrap step 1, saturate step 5).
module tb_regn_ld_step;
  logic clk = 0, rst = 0, ld = 0, inc = 0, dec = 0, shl = 0, shr = 0, sin = 0, clr_flags = 0;
  logic [7:0] in = 0;
  logic [7:0] out0, out1;
  logic zero0, max0, carry0, borrow0, sout0;
  logic zero1, max1, carry1, borrow1, sout1;
`ifdef REGN_LD_STEP_STICKY_EN
  logic os0, us0, os1, us1;
`endif
  always #5 clk = ~clk;

  regn_ld_step #(.WIDTH(8), .STEP(1), .SATURATE(1'b0), .RST_VAL(8'h00)) u0 (
    .clk(clk), .rst(rst), .ld(ld), .inc(inc), .dec(dec), .shl(shl), .shr(shr), .sin(sin), .in(in),
    .out(out0), .zero(zero0), .max(max0), .carry(carry0), .borrow(borrow0), .sout(sout0)
`ifdef REGN_LD_STEP_STICKY_EN
    , .clr_flags(clr_flags), .ovf_sticky(os0), .unf_sticky(us0)
`endif
  );
  regn_ld_step #(.WIDTH(8), .STEP(5), .SATURATE(1'b1), .RST_VAL(8'h3C)) u1 (
    .clk(clk), .rst(rst), .ld(ld), .inc(inc), .dec(dec), .shl(shl), .shr(shr), .sin(sin), .in(in),
    .out(out1), .zero(zero1), .max(max1), .carry(carry1), .borrow(borrow1), .sout(sout1)
`ifdef REGN_LD_STEP_STICKY_EN
    , .clr_flags(clr_flags), .ovf_sticky(os1), .unf_sticky(us1)
`endif
  );

  typedef struct packed {logic [7:0] o; logic c; logic b; logic os; logic us;} exp_t;
  exp_t q0[$], q1[$];
  int v0 = 0, v1 = 0;
  bit os0m = 0, us0m = 0, os1m = 0, us1m = 0;
  int pass = 0, total = 0;

  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act === want) pass++;
    else $display("FAIL %s: got %h expected %h at %0t", n, act, want, $time);
  endtask

  // Reference model: plain integer arithmetic on the register value.
  task automatic model(input int step, input bit sat, input int rv, input bit r, l, i, d, sl, sr, s,
                       input bit clr, input int din, inout int v, inout bit os, inout bit us,
                       output bit c, output bit b);
    c = 0;
    b = 0;
    if (r) begin
      v = rv; os = 0; us = 0;
      return;
    end
    if (l) v = din;
    else if (i && !d) begin
      v = v + step; c = v > 255;
      if (c) v = sat ? 255 : v - 256;
    end else if (d && !i) begin
      v = v - step; b = v < 0;
      if (b) v = sat ? 0 : v + 256;
    end else if (!i && !d && sl && !sr) v = (v * 2 + s) % 256;
    else if (!i && !d && sr && !sl) v = v / 2 + s * 128;
    os = c | (os & !clr);
    us = b | (us & !clr);
  endtask

  task automatic op(input bit r, l, i, d, sl, sr, s, input logic [7:0] din, input bit clr = 0);
    bit c, b;
    @(negedge clk);
    rst = r; ld = l; inc = i; dec = d; shl = sl; shr = sr; sin = s; in = din; clr_flags = clr;
    #1;
    if (!r) begin
      chk("sout0", {7'b0, sout0}, {7'b0, sl ? v0[7] : v0[0]});
      chk("sout1", {7'b0, sout1}, {7'b0, sl ? v1[7] : v1[0]});
    end
    model(1, 0, 8'h00, r, l, i, d, sl, sr, s, clr, int'(din), v0, os0m, us0m, c, b);
    q0.push_back('{o: v0[7:0], c: c, b: b, os: os0m, us: us0m});
    model(5, 1, 8'h3C, r, l, i, d, sl, sr, s, clr, int'(din), v1, os1m, us1m, c, b);
    q1.push_back('{o: v1[7:0], c: c, b: b, os: os1m, us: us1m});
  endtask

  task automatic cmp(input string n, input exp_t e, input logic [7:0] o, input logic c, b, z, m
`ifdef REGN_LD_STEP_STICKY_EN
                     , input logic os, us
`endif
  );
    chk({n, ".out"}, o, e.o);
    chk({n, ".carry"}, {7'b0, c}, {7'b0, e.c});
    chk({n, ".borrow"}, {7'b0, b}, {7'b0, e.b});
    chk({n, ".zero"}, {7'b0, z}, {7'b0, e.o == 8'h00});
    chk({n, ".max"}, {7'b0, m}, {7'b0, e.o == 8'hFF});
`ifdef REGN_LD_STEP_STICKY_EN
    chk({n, ".ovf_sticky"}, {7'b0, os}, {7'b0, e.os});
    chk({n, ".unf_sticky"}, {7'b0, us}, {7'b0, e.us});
`endif
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (q0.size() > 0) begin
      exp_t e;
      e = q0.pop_front();
      cmp("u0", e, out0, carry0, borrow0, zero0, max0
`ifdef REGN_LD_STEP_STICKY_EN
          , os0, us0
`endif
      );
    end
    if (q1.size() > 0) begin
      exp_t e;
      e = q1.pop_front();
      cmp("u1", e, out1, carry1, borrow1, zero1, max1
`ifdef REGN_LD_STEP_STICKY_EN
          , os1, us1
`endif
      );
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass, total);
    $fatal(1);
  end

  initial begin
    //  r  l  i  d  sl sr s  din
    op(1, 0, 0, 0, 0, 0, 0, 8'h00);
    op(0, 1, 0, 0, 0, 0, 0, 8'hFE);
    repeat (3) op(0, 0, 1, 0, 0, 0, 0, 8'h00);
    op(0, 1, 0, 0, 0, 0, 0, 8'h03);
    op(0, 0, 0, 1, 0, 0, 0, 8'h00);
    op(0, 0, 0, 1, 0, 0, 0, 8'h00);
    op(0, 0, 1, 0, 0, 0, 0, 8'h00);
    op(0, 1, 0, 0, 0, 0, 0, 8'h10);
    op(0, 1, 1, 0, 0, 0, 0, 8'hAA);
    op(0, 0, 1, 1, 0, 0, 0, 8'h00);
    op(0, 0, 0, 0, 1, 1, 1, 8'h00);
    op(0, 1, 0, 0, 0, 0, 0, 8'h81);
    op(0, 0, 0, 0, 1, 0, 0, 8'h00);
    op(0, 0, 0, 0, 0, 1, 1, 8'h00);
    op(0, 0, 0, 0, 0, 0, 0, 8'h00);
    op(0, 1, 0, 0, 0, 0, 0, 8'h00);
    op(0, 0, 1, 0, 0, 0, 0, 8'h00);
    op(0, 0, 1, 0, 0, 0, 0, 8'h00);
    op(1, 0, 1, 0, 0, 0, 0, 8'h00);
    op(0, 0, 1, 0, 0, 0, 0, 8'h00);
    op(0, 1, 0, 0, 0, 0, 0, 8'hFF);
    repeat (6) op(0, 0, 1, 0, 0, 0, 0, 8'h00);
    op(0, 1, 0, 0, 0, 0, 0, 8'hFF);
    op(0, 0, 1, 0, 0, 0, 0, 8'h00, 1);
    op(0, 0, 0, 0, 0, 0, 0, 8'h00, 1);
    op(0, 1, 0, 0, 0, 0, 0, 8'h00);
    op(0, 0, 0, 1, 0, 0, 0, 8'h00, 1);
    op(0, 0, 0, 0, 0, 0, 0, 8'h00, 1);
    for (int k = 0; k < 400; k++)
      op($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
         $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
         1'($urandom), 8'($urandom), $urandom_range(0, 9) == 0);
    repeat (3) @(negedge clk);
    chk("queue0_drained", 8'(q0.size()), 8'd0);
    chk("queue1_drained", 8'(q1.size()), 8'd0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
